ray_direction_normalizer: RTL

- Upstream stage of the ray stepper. Takes a raw, non-zero signed ray direction and its origin, and rescales the direction so its Euclidean length lies strictly in (sqrt(3)/2, 1).
- That length range is the input precondition of the stepper.
- Uses an iterative measure/adjust FSM: coarse power-of-two shifts first, then fine ×(1+1/8) growth steps.
- The origin passes through untouched, so the output can drive the stepper's start/q/v directly.

---
 rtl/ray_direction_normalizer.sv | 119 +++++++++++
 1 files changed

// File: rtl/ray_direction_normalizer.sv
// Rescales a non-zero signed direction so its length lies in (sqrt(3)/2, 1); the origin passes through.
// Latency: 2N+3 cycles for N adjust operations (N <= 20 at WIDTH=16); an all-zero input takes 1 cycle.
// Backpressure: in_ready only in IDLE; out_valid and the result are held until out_ready.
//
// Packed component order for d_in/q_in/v_out/q_out: x = [WIDTH-1:0], y = next WIDTH bits, z = top bits.
module ray_direction_normalizer #(
  parameter int WIDTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3*WIDTH-1:0] d_in,
  input  logic [3*WIDTH-1:0] q_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3*WIDTH-1:0] v_out,
  output logic [3*WIDTH-1:0] q_out,
  output logic               err
);

  localparam int LW = 2*WIDTH + 2;

  // Squared-length thresholds in units where 1.0^2 = 2^(2*WIDTH-2).
  localparam logic [LW-1:0] ONE     = {{(LW-1){1'b0}}, 1'b1} << (2*WIDTH-2);
  localparam logic [LW-1:0] QUARTER = ONE >> 2;
  localparam logic [LW-1:0] THREE_Q = QUARTER + (QUARTER << 1);

  typedef enum logic [1:0] {IDLE, MEASURE, ADJUST, DONE} state_t;

  state_t state, state_next;

  logic signed [WIDTH-1:0]   v     [3];
  logic signed [WIDTH-1:0]   v_shr [3];
  logic signed [WIDTH-1:0]   v_shl [3];
  logic signed [WIDTH-1:0]   v_grow[3];
  logic signed [2*WIDTH-1:0] sq    [3];
  logic [LW-1:0]             l2;
  logic [LW-1:0]             l2_calc;
  logic                      in_range;

  // Squared length of the working vector plus the three candidate adjustments.
  always_comb begin
    l2_calc = '0;
    for (int i = 0; i < 3; i++) begin
      sq[i]     = v[i] * v[i];
      l2_calc   = l2_calc + {2'b00, sq[i]};
      v_shr[i]  = v[i] >>> 1;
      v_shl[i]  = v[i] << 1;
      v_grow[i] = v[i] + (v[i] >>> 3);
    end
  end

  assign in_range = (l2 > THREE_Q) && (l2 < ONE);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = (d_in == '0) ? DONE : MEASURE;
      end
      MEASURE: state_next = ADJUST;
      ADJUST:  state_next = in_range ? DONE : MEASURE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch inputs, measure, apply one coarse or fine adjustment per ADJUST visit.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) v[i] <= '0;
      l2    <= '0;
      v_out <= '0;
      q_out <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < 3; i++) v[i] <= d_in[i*WIDTH +: WIDTH];
            q_out <= q_in;
            if (d_in == '0) begin
              v_out <= '0;
              err   <= 1'b1;
            end else begin
              err   <= 1'b0;
            end
          end
        end
        MEASURE: l2 <= l2_calc;
        ADJUST: begin
          // Too long: one halving suffices since |d|^2 <= 3.
          if (l2 >= ONE)          v <= v_shr;
          // Far too short: doubling cannot overflow because every |c| < 0.5.
          else if (l2 < QUARTER)  v <= v_shl;
          // Slightly short: x1.125 per component, at most x1.2656 in length^2.
          else if (l2 <= THREE_Q) v <= v_grow;
          else                    v_out <= {v[2], v[1], v[0]};
        end
        default: ;
      endcase
    end
  end

endmodule
